// File: rtl/xbar_slave_responder.sv
// xbar_slave_responder: slave-side endpoint of the crossbar request/response
// protocol. A three-state FSM (IDLE/WAIT/ACK) accepts one request per ack,
// writes land in a local register-file memory, and reads return through a
// fixed-latency valid/data shift pipeline as a one-cycle response pulse.
module xbar_slave_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int RD_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slv_req,
  input  logic [ADDR_W-1:0] slv_addr,
  input  logic              slv_cmd,
  input  logic [DATA_W-1:0] slv_wdata,
  output logic              slv_ack,
  output logic              slv_resp,
  output logic [DATA_W-1:0] slv_rdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_q;
  logic [DATA_W-1:0] mem_q       [MEM_DEPTH];
  logic              pipe_vld_q  [RD_LATENCY];
  logic [DATA_W-1:0] pipe_data_q [RD_LATENCY];

  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic              unused_addr;

  // Only the low index bits select a word; upper address bits alias.
  assign idx         = slv_addr[IDX_W-1:0];
  assign unused_addr = ^slv_addr[ADDR_W-1:IDX_W];

  // The request is accepted at the edge that ends the ACK cycle.
  assign accept = (state_q == ST_ACK);
  assign wr_en  = accept &  slv_cmd;
  assign rd_en  = accept & ~slv_cmd;

  // Next-state logic: count out the wait, abandon if the master lets go.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (slv_req) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!slv_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, wait counter and the registered ack pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == ST_ACK);
    end
  end

  // Local memory: written on an accepted write.
  always_ff @(posedge clk) begin
    // NOTE: the memory must read back as zero after reset, so it is built
    // from resettable flops rather than an inferred RAM macro.
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= slv_wdata;
    end
  end

  // Read pipeline: capture on an accepted read, shift every cycle, never stall.
  // Data is zeroed on bubbles so the last stage drives slv_rdata directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_en;
      pipe_data_q[0] <= rd_en ? mem_q[idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign slv_ack   = ack_q;
  assign slv_resp  = pipe_vld_q[RD_LATENCY-1];
  assign slv_rdata = pipe_data_q[RD_LATENCY-1];

endmodule
